pll_lock_monitor: RTL and testbench

Consumes the asynchronous LOCK output of the 12→100 MHz PLL and turns it into a clean, glitch-qualified reset for all logic in the clk_100m domain. It qualifies lock by requiring a minimum stable interval, then holds reset for a fixed interval before releasing it. It re-asserts reset on any loss of lock and records the number of loss events. It sits directly after the PLL at top level and drives the reset of the TDC core.

---
 rtl/pll_mon_pkg.sv | 18 +
 rtl/bit_sync.sv | 27 ++
 rtl/pll_lock_monitor.sv | 129 ++++++++++++
 tb/tb_pll_lock_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor and its synchronizer.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } mon_state_e;

    // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchronizer for asynchronous level inputs; clears to 0 on reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("bit_sync: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the asynchronous PLL lock and generates a clean reset for the clk_100m domain,
// counting every loss of lock seen while running.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned STABLE_CYCLES     = 1024,
    parameter int unsigned RESET_HOLD_CYCLES = 16,
    parameter int unsigned LOSS_CNT_W        = 8
) (
    input  logic                  clk_100m,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  clear_count,
    output logic                  rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pll_lock_monitor: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("pll_lock_monitor: STABLE_CYCLES must be >= 1");
    end
    if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("pll_lock_monitor: RESET_HOLD_CYCLES must be >= 1");
    end
    if (LOSS_CNT_W < 1) begin : g_bad_loss_w
        $error("pll_lock_monitor: LOSS_CNT_W must be >= 1");
    end

    logic                  locked_s;
    mon_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lost_d;
    logic [LOSS_CNT_W-1:0] count_d;

    // Raw lock is only ever observed through this synchronizer.
    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk_100m),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out    <= (state_d != RUN);
            ready      <= (state_d == RUN);
            lock_lost  <= lost_d;
            loss_count <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        count_d = loss_count;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // A loss coinciding with a clear is kept as the first event after the clear.
        if (clear_count) begin
            count_d = lost_d ? LOSS_CNT_W'(1) : '0;
        end else if (lost_d && (loss_count != LOSS_MAX)) begin
            count_d = loss_count + LOSS_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: a streak-based lock model predicts every cycle's outputs.
module tb_pll_lock_monitor;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 8;
    localparam int unsigned HOLDC  = 4;
    localparam int unsigned LW     = 2;
    localparam int          QUAL   = STABLE + HOLDC + 1;
    localparam int          CMAX   = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          clear_count = 1'b0;
    logic          rst_out, ready, lock_lost;
    logic [LW-1:0] loss_count;

    typedef struct packed {
        logic          rst_out;
        logic          ready;
        logic          lock_lost;
        logic [LW-1:0] count;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: ready once locked_s has been high for QUAL consecutive edges since reset.
    bit   sh[SYNC];
    int   streak  = 0;
    bit   m_ready = 1'b0;
    bit   m_lost  = 1'b0;
    int   m_count = 0;

    always #5 clk = ~clk;

    pll_lock_monitor #(
        .SYNC_STAGES       (SYNC),
        .STABLE_CYCLES     (STABLE),
        .RESET_HOLD_CYCLES (HOLDC),
        .LOSS_CNT_W        (LW)
    ) dut (
        .clk_100m    (clk),
        .rst         (rst),
        .locked      (locked),
        .clear_count (clear_count),
        .rst_out     (rst_out),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .loss_count  (loss_count)
    );

    task automatic step(input bit r, input bit l, input bit c);
        bit   ls;
        exp_t e;
        rst         = r;
        locked      = l;
        clear_count = c;
        if (r) begin
            for (int i = 0; i < int'(SYNC); i++) sh[i] = 1'b0;
            streak  = 0;
            m_ready = 1'b0;
            m_lost  = 1'b0;
            m_count = 0;
        end else begin
            ls = sh[SYNC-1];
            for (int i = int'(SYNC) - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0]  = l;
            streak = ls ? ((streak < QUAL) ? streak + 1 : QUAL) : 0;
            m_lost  = m_ready && !ls;
            m_ready = (streak >= QUAL);
            if (c) m_count = m_lost ? 1 : 0;
            else if (m_lost && m_count < CMAX) m_count = m_count + 1;
        end
        e.rst_out   = !m_ready;
        e.ready     = m_ready;
        e.lock_lost = m_lost;
        e.count     = LW'(m_count);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_direct(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expected entry per edge, compared just after that edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (rst_out !== e.rst_out) begin
                miscompares++;
                $display("FAIL rst_out: got %b want %b at %0t", rst_out, e.rst_out, $time);
            end
            if (ready !== e.ready) begin
                miscompares++;
                $display("FAIL ready: got %b want %b at %0t", ready, e.ready, $time);
            end
            if (lock_lost !== e.lock_lost) begin
                miscompares++;
                $display("FAIL lock_lost: got %b want %b at %0t", lock_lost, e.lock_lost, $time);
            end
            if (loss_count !== e.count) begin
                miscompares++;
                $display("FAIL loss_count: got %0d want %0d at %0t", loss_count, e.count, $time);
            end
        end
    end

    initial begin
        int remaining;
        bit lv;

        // Power-up with lock already present during reset.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        check_direct("reset_rst_out", rst_out, 1'b1);
        check_direct("reset_ready", ready, 1'b0);
        repeat (14) step(1'b0, 1'b1, 1'b0);
        check_direct("pre_lock_ready", ready, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_direct("lock_edge15_ready", ready, 1'b1);
        check_direct("lock_edge15_rst_out", rst_out, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);

        // Loss in RUN, then a bounce during qualification.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0);

        // Saturate the loss counter.
        repeat (5) begin
            repeat (3) step(1'b0, 1'b0, 1'b0);
            repeat (16) step(1'b0, 1'b1, 1'b0);
        end
        check_direct("saturated_bit0", loss_count[0], 1'b1);
        check_direct("saturated_bit1", loss_count[1], 1'b1);

        // Clear on the same edge the loss is seen.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_direct("clear_with_loss_bit0", loss_count[0], 1'b1);
        check_direct("clear_with_loss_bit1", loss_count[1], 1'b0);
        repeat (18) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Reset while in HOLD, then a full qualification.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (13) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_direct("midhold_rst_out", rst_out, 1'b1);
        check_direct("midhold_ready", ready, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0);

        // Randomized lock stretches with occasional clears and resets.
        remaining = 0;
        lv = 1'b1;
        repeat (800) begin
            if (remaining == 0) begin
                lv = ~lv;
                remaining = lv ? $urandom_range(1, 25) : $urandom_range(1, 4);
            end
            step(($urandom_range(0, 199) == 0), lv, ($urandom_range(0, 29) == 0));
            remaining--;
        end

        repeat (2) @(posedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
